shift_reg_univ: RTL and testbench

//  Parametrised universal shift register with per-cycle mode select. It is the successor to the fixed 4-bit serial-in shifter.

---
 rtl/shift_reg_univ_pkg.sv | 25 ++
 rtl/shift_reg_univ_dff_en_rn.sv | 21 ++
 rtl/shift_reg_univ.sv | 107 ++++++++++
 tb/tb_shift_reg_univ.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// counter width formula and a shift-op classifier.
package shift_reg_univ_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ASR   = 3'b101,
    MODE_LOAD  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  // Enough bits to hold 0..WIDTH, so WIDTH-1 always fits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic is_shift(input mode_e m);
    return (m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});
  endfunction

endpackage

// File: rtl/shift_reg_univ_dff_en_rn.sv
// dff_en_rn: single-bit flop with enable and asynchronous active-low reset
// to a parametrised value.
module shift_reg_univ_dff_en_rn #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic En,
  input  logic D,
  output logic Q
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Q <= RST_VAL;
    end else if (En) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: per-bit next-value muxes feeding enable flops,
// plus a frame counter that pulses FrameDone every WIDTH shift ops.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int              WIDTH      = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int             CW         = cnt_width(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic             SerInL,
  input  logic             SerInR,
  input  logic [WIDTH-1:0] ParIn,
  output logic [WIDTH-1:0] Out,
  output logic             SerOutL,
  output logic             SerOutR,
  output logic [CW-1:0]    ShiftCnt,
  output logic             FrameDone
);

  mode_e            mode;
  logic [WIDTH-1:0] out_reg;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             frame_done_reg, frame_done_next;

  assign mode = mode_e'(Mode);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic from_lo;   // neighbour feeding this bit on a left move
      logic from_hi;   // neighbour feeding this bit on a right move
      logic bit_next;

      if (gi == 0) begin : g_lsb
        assign from_lo = (mode == MODE_SHL) ? SerInR : out_reg[WIDTH-1];
      end else begin : g_lo
        assign from_lo = out_reg[gi-1];
      end

      // Top bit takes serial input, wrapped LSB, or its own sign for ASR.
      if (gi == WIDTH - 1) begin : g_msb
        assign from_hi = (mode == MODE_SHR) ? SerInL :
                         (mode == MODE_ROR) ? out_reg[0] : out_reg[WIDTH-1];
      end else begin : g_hi
        assign from_hi = out_reg[gi+1];
      end

      always_comb begin
        bit_next = out_reg[gi];
        case (mode)
          MODE_SHL, MODE_ROL:           bit_next = from_lo;
          MODE_SHR, MODE_ROR, MODE_ASR: bit_next = from_hi;
          MODE_LOAD:                    bit_next = ParIn[gi];
          MODE_CLEAR:                   bit_next = 1'b0;
          default:                      bit_next = out_reg[gi];
        endcase
      end

      shift_reg_univ_dff_en_rn #(
        .RST_VAL (INIT_VALUE[gi])
      ) u_dff (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (En),
        .D     (bit_next),
        .Q     (out_reg[gi])
      );
    end
  endgenerate

  always_comb begin
    cnt_next        = cnt_reg;
    frame_done_next = 1'b0;
    if (En) begin
      if (is_shift(mode)) begin
        if (cnt_reg == CW'(WIDTH - 1)) begin
          cnt_next        = '0;
          frame_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end else if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
        cnt_next = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign Out       = out_reg;
  assign SerOutL   = out_reg[WIDTH-1];
  assign SerOutR   = out_reg[0];
  assign ShiftCnt  = cnt_reg;
  assign FrameDone = frame_done_reg;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: two instances (reset values 0 and 4'hA)
// share one stimulus sequence; expectations are hand-computed.
module tb_shift_reg_univ;

  logic       Clk;
  logic       Rst_n;
  logic       En;
  logic [2:0] Mode;
  logic       SerInL;
  logic       SerInR;
  logic [3:0] ParIn;

  logic [3:0] out0, outa;
  logic       sol0, sor0, sola, sora;
  logic [2:0] cnt0, cnta;
  logic       fd0, fda;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [2:0] M_HOLD = 3'b000, M_SHL = 3'b001, M_SHR = 3'b010,
                         M_ROL = 3'b011, M_ROR = 3'b100, M_ASR = 3'b101,
                         M_LOAD = 3'b110, M_CLEAR = 3'b111;

  shift_reg_univ #(.WIDTH(4), .INIT_VALUE(4'h0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Mode(Mode), .SerInL(SerInL),
    .SerInR(SerInR), .ParIn(ParIn), .Out(out0), .SerOutL(sol0),
    .SerOutR(sor0), .ShiftCnt(cnt0), .FrameDone(fd0)
  );

  shift_reg_univ #(.WIDTH(4), .INIT_VALUE(4'hA)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Mode(Mode), .SerInL(SerInL),
    .SerInR(SerInR), .ParIn(ParIn), .Out(outa), .SerOutL(sola),
    .SerOutR(sora), .ShiftCnt(cnta), .FrameDone(fda)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Checks the INIT_VALUE=0 instance.
  task automatic chk3(input string tag, input logic [3:0] e_out,
                      input logic [2:0] e_cnt, input logic e_fd);
    chk({tag, ".out"}, {4'h0, out0}, {4'h0, e_out});
    chk({tag, ".cnt"}, {5'h0, cnt0}, {5'h0, e_cnt});
    chk({tag, ".fd"},  {7'h0, fd0},  {7'h0, e_fd});
    $display("[TB] %s out=%b cnt=%0d fd=%0b", tag, out0, cnt0, fd0);
  endtask

  task automatic op(input logic [2:0] m);
    Mode = m;
    tick();
  endtask

  initial begin
    Rst_n = 1'b0; En = 1'b0; Mode = M_HOLD;
    SerInL = 1'b0; SerInR = 1'b0; ParIn = 4'h0;
    #7;
    chk3("rst0", 4'h0, 3'd0, 1'b0);
    chk("rsta.out", {4'h0, outa}, 8'h0A);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Test 1: async reset mid-cycle restores INIT_VALUE before the next edge
    En = 1'b1; ParIn = 4'h5;
    op(M_LOAD);
    chk3("t1.load", 4'h5, 3'd0, 1'b0);
    chk("t1.loada", {4'h0, outa}, 8'h05);
    SerInR = 1'b1;
    op(M_SHL);
    chk3("t1.shl", 4'hB, 3'd1, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    chk("t1.rsta.out", {4'h0, outa}, 8'h0A);
    chk("t1.rsta.cnt", {5'h0, cnta}, 8'h00);
    chk("t1.rsta.fd",  {7'h0, fda},  8'h00);
    chk3("t1.rst0", 4'h0, 3'd0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Test 2: serial fill from LSB
    SerInR = 1'b1; op(M_SHL); chk3("t2.s1", 4'b0001, 3'd1, 1'b0);
    SerInR = 1'b0; op(M_SHL); chk3("t2.s2", 4'b0010, 3'd2, 1'b0);
    SerInR = 1'b1; op(M_SHL); chk3("t2.s3", 4'b0101, 3'd3, 1'b0);
    SerInR = 1'b1; op(M_SHL); chk3("t2.s4", 4'b1011, 3'd0, 1'b1);
    chk("t2.serl", {7'h0, sol0}, 8'h01);
    chk("t2.serr", {7'h0, sor0}, 8'h01);
    op(M_HOLD); chk3("t2.hold", 4'b1011, 3'd0, 1'b0);

    // Test 3: rotates and arithmetic shift
    ParIn = 4'b1001;
    op(M_LOAD); chk3("t3.load", 4'b1001, 3'd0, 1'b0);
    op(M_ROL);  chk3("t3.rol",  4'b0011, 3'd1, 1'b0);
    op(M_ROR);  chk3("t3.ror",  4'b1001, 3'd2, 1'b0);
    op(M_ASR);  chk3("t3.asr1", 4'b1100, 3'd3, 1'b0);
    op(M_ASR);  chk3("t3.asr2", 4'b1110, 3'd0, 1'b1);
    chk("t3.serr", {7'h0, sor0}, 8'h00);

    // Test 4: enable low and HOLD both freeze state
    ParIn = 4'h6;
    op(M_LOAD); chk3("t4.load", 4'h6, 3'd0, 1'b0);
    op(M_ROL);  chk3("t4.rol",  4'b1100, 3'd1, 1'b0);
    op(M_ROR);  chk3("t4.ror",  4'h6, 3'd2, 1'b0);
    En = 1'b0; SerInL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(M_SHR); chk3("t4.en0", 4'h6, 3'd2, 1'b0);
    end
    En = 1'b1;
    op(M_HOLD); chk3("t4.hold", 4'h6, 3'd2, 1'b0);
    op(M_ROL);  chk3("t4.rol3", 4'b1100, 3'd3, 1'b0);
    En = 1'b0;
    op(M_ROL);  chk3("t4.en0wrap", 4'b1100, 3'd3, 1'b0);
    En = 1'b1;

    // Test 5: CLEAR aborts a frame without FrameDone
    op(M_CLEAR); chk3("t5.clr0", 4'h0, 3'd0, 1'b0);
    SerInL = 1'b0;
    op(M_SHR); chk3("t5.shr1", 4'h0, 3'd1, 1'b0);
    op(M_SHR); chk3("t5.shr2", 4'h0, 3'd2, 1'b0);
    op(M_CLEAR); chk3("t5.clr", 4'h0, 3'd0, 1'b0);
    SerInL = 1'b1;
    op(M_SHR); chk3("t5.f1", 4'b1000, 3'd1, 1'b0);
    op(M_SHR); chk3("t5.f2", 4'b1100, 3'd2, 1'b0);
    op(M_SHR); chk3("t5.f3", 4'b1110, 3'd3, 1'b0);
    op(M_SHR); chk3("t5.f4", 4'b1111, 3'd0, 1'b1);
    op(M_HOLD); chk3("t5.hold", 4'b1111, 3'd0, 1'b0);

    // Test 6: reset mid-frame discards the partial count
    SerInR = 1'b0;
    op(M_SHL); chk3("t6.a1", 4'b1110, 3'd1, 1'b0);
    op(M_SHL); chk3("t6.a2", 4'b1100, 3'd2, 1'b0);
    op(M_SHL); chk3("t6.a3", 4'b1000, 3'd3, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    chk3("t6.rst", 4'h0, 3'd0, 1'b0);
    chk("t6.rsta.out", {4'h0, outa}, 8'h0A);
    @(negedge Clk);
    Rst_n = 1'b1;
    SerInR = 1'b1;
    op(M_SHL); chk3("t6.b1", 4'b0001, 3'd1, 1'b0);
    op(M_SHL); chk3("t6.b2", 4'b0011, 3'd2, 1'b0);
    op(M_SHL); chk3("t6.b3", 4'b0111, 3'd3, 1'b0);
    chk("t6.serl", {7'h0, sol0}, 8'h00);
    chk("t6.serr", {7'h0, sor0}, 8'h01);
    op(M_SHL); chk3("t6.b4", 4'b1111, 3'd0, 1'b1);
    chk("t6.a.cnt", {5'h0, cnta}, 8'h00);
    chk("t6.a.fd",  {7'h0, fda},  8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
